// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and FSM state encoding for irq_requester.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int c_N_LINES_DEF    = 4;
    localparam int c_DEB_CYCLES_DEF = 16;
    localparam int c_CNT_W_DEF      = 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_SERV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_REQ  = c_ST_REQ,
        ST_SERV = c_ST_SERV
    } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_debounce.sv
`default_nettype none
// ============================================================================
// Module      : irq_debounce
// Description : 2-FF synchronizer, debounce counter and rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_debounce
    import irq_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter tracks consecutive samples that disagree with r_stable;
    // the DEB_CYCLES-th disagreeing sample is accepted.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync2;
                r_rise   <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/irq_requester.sv
`default_nettype none
// ============================================================================
// Module      : irq_requester
// Description : Debounced button-to-interrupt request generator with a
//               one-deep per-line request queue and saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_requester
    import irq_pkg::*;
#(
    parameter int N_LINES    = c_N_LINES_DEF,
    parameter int DEB_CYCLES = c_DEB_CYCLES_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               in_RST,
    input  logic [N_LINES-1:0] btn_raw,
    input  logic [N_LINES-1:0] IG,
    output logic [N_LINES-1:0] in_IR,
    output logic [N_LINES-1:0] pend_again,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int                 c_SUM_W   = CNT_W + $clog2(N_LINES + 1);
    localparam logic [c_SUM_W-1:0] c_CNT_SAT = {{(c_SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [N_LINES-1:0] w_event;
    irq_state_e         r_state     [N_LINES];
    irq_state_e         w_state_nxt [N_LINES];
    logic [N_LINES-1:0] r_queued;
    logic [N_LINES-1:0] w_queued_nxt;
    logic [N_LINES-1:0] r_ir;
    logic [N_LINES-1:0] w_drop;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [c_SUM_W-1:0] w_drop_sum;
    logic [c_SUM_W-1:0] w_cnt_total;
    logic [CNT_W-1:0]   w_cnt_nxt;

    generate
        for (genvar gi = 0; gi < N_LINES; gi++) begin : g_deb
            irq_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .i_rst (in_RST),
                .i_raw (btn_raw[gi]),
                .o_rise(w_event[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_queued_nxt = r_queued;
        w_drop       = '0;
        for (int i = 0; i < N_LINES; i++) begin
            case (r_state[i])
                ST_IDLE: begin
                    if (w_event[i]) w_state_nxt[i] = ST_REQ;
                end
                ST_REQ: begin
                    if (IG[i]) begin
                        w_state_nxt[i]  = ST_SERV;
                        w_queued_nxt[i] = w_event[i];
                    end else if (w_event[i]) begin
                        w_drop[i] = 1'b1;
                    end
                end
                ST_SERV: begin
                    if (!IG[i]) begin
                        // A queued request and a fresh event collapse into
                        // one re-request with one still queued behind it.
                        if (r_queued[i]) begin
                            w_state_nxt[i]  = ST_REQ;
                            w_queued_nxt[i] = w_event[i];
                        end else if (w_event[i]) begin
                            w_state_nxt[i]  = ST_REQ;
                        end else begin
                            w_state_nxt[i]  = ST_IDLE;
                        end
                    end else if (w_event[i]) begin
                        if (r_queued[i]) w_drop[i]       = 1'b1;
                        else             w_queued_nxt[i] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i]  = ST_IDLE;
                    w_queued_nxt[i] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < N_LINES; i++) begin
            w_drop_sum = w_drop_sum + c_SUM_W'(w_drop[i]);
        end
        w_cnt_total = c_SUM_W'(r_drop_cnt) + w_drop_sum;
        w_cnt_nxt   = (w_cnt_total > c_CNT_SAT) ? {CNT_W{1'b1}} : w_cnt_total[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (in_RST) begin
            for (int i = 0; i < N_LINES; i++) begin
                r_state[i] <= ST_IDLE;
            end
            r_queued   <= '0;
            r_ir       <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_LINES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_ir[i]    <= (w_state_nxt[i] == ST_REQ);
            end
            r_queued   <= w_queued_nxt;
            r_drop_cnt <= w_cnt_nxt;
        end
    end

    assign in_IR      = r_ir;
    assign pend_again = r_queued;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_requester
// Description : Directed self-checking bench for irq_requester (DEB_CYCLES=4),
//               with a second instance using a 2-bit drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_requester;

    logic       clk;
    logic       in_RST;
    logic [3:0] btn_raw;
    logic [3:0] IG;
    logic [3:0] in_IR;
    logic [3:0] pend_again;
    logic [7:0] drop_cnt;
    logic [3:0] in_IR_s;
    logic [3:0] pend_again_s;
    logic [1:0] drop_cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    irq_requester #(
        .N_LINES(4), .DEB_CYCLES(4), .CNT_W(8)
    ) u_dut (
        .clk       (clk),
        .in_RST    (in_RST),
        .btn_raw   (btn_raw),
        .IG        (IG),
        .in_IR     (in_IR),
        .pend_again(pend_again),
        .drop_cnt  (drop_cnt)
    );

    irq_requester #(
        .N_LINES(4), .DEB_CYCLES(4), .CNT_W(2)
    ) u_dut_sat (
        .clk       (clk),
        .in_RST    (in_RST),
        .btn_raw   (btn_raw),
        .IG        (IG),
        .in_IR     (in_IR_s),
        .pend_again(pend_again_s),
        .drop_cnt  (drop_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press: high long enough to produce the event, then low long
    // enough for the debouncer to settle back to 0.
    task automatic press(input logic [3:0] m);
        btn_raw = m;
        repeat (7) tick();
        btn_raw = '0;
        repeat (7) tick();
    endtask

    initial begin
        in_RST  = 1'b1;
        btn_raw = '0;
        IG      = '0;
        tick();
        tick();
        in_RST = 1'b0;
        tick();
        check("rst_ir",       32'(in_IR),        32'h0);
        check("rst_pend",     32'(pend_again),   32'h0);
        check("rst_drop",     32'(drop_cnt),     32'h0);
        check("rst_drop_sat", 32'(drop_cnt_s),   32'h0);

        // Clean press on line 0: request appears after edge 6
        btn_raw[0] = 1'b1;
        repeat (6) tick();
        check("press0_e5", 32'(in_IR), 32'h0);
        tick();
        check("press0_e6", 32'(in_IR), 32'h1);
        repeat (3) tick();
        IG[0] = 1'b1;
        tick();
        check("grant0_ir", 32'(in_IR), 32'h0);
        btn_raw[0] = 1'b0;
        repeat (8) tick();
        IG[0] = 1'b0;
        tick();
        check("rel0_ir",   32'(in_IR),      32'h0);
        check("rel0_pend", 32'(pend_again), 32'h0);
        check("rel0_drop", 32'(drop_cnt),   32'h0);
        repeat (4) tick();
        check("idle0_ir",  32'(in_IR),      32'h0);

        // Bounce on line 1: toggling every 2 cycles never qualifies
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = ~btn_raw[1];
            tick();
            tick();
        end
        check("bounce_ir",   32'(in_IR),    32'h0);
        check("bounce_drop", 32'(drop_cnt), 32'h0);
        btn_raw[1] = 1'b1;
        repeat (6) tick();
        check("bounce_e5", 32'(in_IR), 32'h0);
        tick();
        check("bounce_e6", 32'(in_IR), 32'h2);
        IG[1] = 1'b1;
        tick();
        IG[1] = 1'b0;
        tick();
        btn_raw[1] = 1'b0;
        repeat (8) tick();
        check("bounce_idle", 32'(in_IR),    32'h0);
        check("bounce_nodrop", 32'(drop_cnt), 32'h0);

        // Queue and drops on line 2 while in service
        press(4'b0100);
        check("q_req", 32'(in_IR), 32'h4);
        IG[2] = 1'b1;
        tick();
        check("q_serv_ir", 32'(in_IR), 32'h0);
        press(4'b0100);
        press(4'b0100);
        press(4'b0100);
        check("q_serv_ir2", 32'(in_IR),      32'h0);
        check("q_pend",     32'(pend_again), 32'h4);
        check("q_drop",     32'(drop_cnt),   32'h2);
        check("q_drop_sat", 32'(drop_cnt_s), 32'h2);
        IG[2] = 1'b0;
        tick();
        check("q_rereq_ir",   32'(in_IR),      32'h4);
        check("q_rereq_pend", 32'(pend_again), 32'h0);
        IG[2] = 1'b1;
        tick();
        IG[2] = 1'b0;
        tick();
        check("q_idle", 32'(in_IR), 32'h0);

        // Event on line 3 in the same cycle its grant rises
        press(4'b1000);
        check("sim_req", 32'(in_IR), 32'h8);
        btn_raw[3] = 1'b1;
        repeat (6) tick();
        IG[3] = 1'b1;
        tick();
        check("sim_serv_ir",   32'(in_IR),      32'h0);
        check("sim_serv_pend", 32'(pend_again), 32'h8);
        check("sim_serv_drop", 32'(drop_cnt),   32'h2);
        btn_raw[3] = 1'b0;
        repeat (7) tick();
        IG[3] = 1'b0;
        tick();
        check("sim_rereq_ir",   32'(in_IR),      32'h8);
        check("sim_rereq_pend", 32'(pend_again), 32'h0);
        IG[3] = 1'b1;
        tick();
        IG[3] = 1'b0;
        tick();
        check("sim_idle", 32'(in_IR), 32'h0);

        // All four lines drop in the same cycle
        press(4'hF);
        check("all_req",  32'(in_IR),    32'hF);
        check("all_drop0", 32'(drop_cnt), 32'h2);
        press(4'hF);
        check("all_ir",       32'(in_IR),      32'hF);
        check("all_pend",     32'(pend_again), 32'h0);
        check("all_drop",     32'(drop_cnt),   32'h6);
        check("all_drop_sat", 32'(drop_cnt_s), 32'h3);
        check("all_ir_sat",   32'(in_IR_s),    32'hF);

        // Reset while all lines are requesting
        in_RST = 1'b1;
        tick();
        check("mid_rst_ir",       32'(in_IR),      32'h0);
        check("mid_rst_pend",     32'(pend_again), 32'h0);
        check("mid_rst_drop",     32'(drop_cnt),   32'h0);
        check("mid_rst_drop_sat", 32'(drop_cnt_s), 32'h0);
        in_RST = 1'b0;
        repeat (4) tick();
        check("post_rst_ir",   32'(in_IR),    32'h0);
        check("post_rst_drop", 32'(drop_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
